// File: rtl/ff_chain_test_ctrl.sv
// ff_chain_test_ctrl: PRBS fill/compare BIST sequencer for a serial flip-flop chain (FF_CHAIN_TEST_INJECT_EN adds inject_err_i)
module ff_chain_test_ctrl #(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FF_CHAIN_TEST_INJECT_EN
  input  logic             inject_err_i,
`endif
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [15:0]      seed_i,
  input  logic [CNT_W-1:0] n_shifts_i,
  output logic             chain_d_o,
  output logic             chain_en_o,
  input  logic             chain_q_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] first_err_o
);
  localparam int CW = $clog2(CHAIN_LEN) > CNT_W ? $clog2(CHAIN_LEN) : CNT_W;
  localparam logic [CW-1:0] FILL_LAST = CW'(CHAIN_LEN - 1);
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] gen_q, gen_d, chk_q, chk_d;
  logic [CNT_W-1:0] n_q, n_d, err_q, err_d, first_q, first_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pass_q, pass_d, active, inj;
  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  assign active = state_q == FILL || state_q == RUN;
`ifdef FF_CHAIN_TEST_INJECT_EN
  logic flag_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) flag_q <= 1'b0;
    else flag_q <= inject_err_i | (flag_q & ~active);
  assign inj = flag_q;
`else
  assign inj = 1'b0;
`endif
  assign chain_en_o  = active;
  assign busy_o      = active;
  assign chain_d_o   = active & (gen_q[15] ^ inj);
  assign done_o      = state_q == DONE;
  assign pass_o      = done_o ? err_q == '0 : pass_q;
  assign err_cnt_o   = err_q;
  assign first_err_o = first_q;
  always_comb begin
    state_d = state_q;
    gen_d   = gen_q;
    chk_d   = chk_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (start_i && !abort_i) begin
        state_d = FILL;
        gen_d   = seed_i == 16'h0 ? 16'h1 : seed_i;
        chk_d   = seed_i == 16'h0 ? 16'h1 : seed_i;
        n_d     = n_shifts_i;
        cnt_d   = '0;
        err_d   = '0;
        first_d = '1;
        pass_d  = 1'b0;
      end
      FILL: begin
        gen_d = lfsr_nx(gen_q);
        cnt_d = cnt_q == FILL_LAST ? '0 : cnt_q + CW'(1);
        if (cnt_q == FILL_LAST) state_d = n_q == '0 ? DONE : RUN;
      end
      RUN: begin
        gen_d = lfsr_nx(gen_q);
        chk_d = lfsr_nx(chk_q);
        cnt_d = cnt_q + CW'(1);
        if (chain_q_i != chk_q[15]) begin
          err_d   = &err_q ? err_q : err_q + CNT_W'(1);
          first_d = &first_q ? CNT_W'(cnt_q) : first_q;
        end
        if (cnt_q == CW'(n_q) - CW'(1)) state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        pass_d  = err_q == '0;
      end
    endcase
    if (abort_i && active) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      gen_q   <= 16'h1;
      chk_q   <= 16'h1;
      n_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      first_q <= '1;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
      chk_q   <= chk_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
endmodule

// File: tb/tb_ff_chain_test_ctrl.sv
// tb_ff_chain_test_ctrl: randomized self-checking bench with a PRBS stream model and a FUT chain model
module tb_ff_chain_test_ctrl;
  localparam int L = 64;
  localparam int CW = 16;
  logic clk = 0, rst = 1, start_i = 0, abort_i = 0;
  logic [15:0] seed_i = 0;
  logic [CW-1:0] n_shifts_i = 0;
  logic chain_d_o, chain_en_o, chain_q_i, busy_o, done_o, pass_o;
  logic [CW-1:0] err_cnt_o, first_err_o;
`ifdef FF_CHAIN_TEST_INJECT_EN
  logic inject_err_i = 0;
`endif
  logic [L-1:0] ch = '0;
  logic stuck = 0;
  bit ref_q[$];
  bit d_q[$];
  int checks = 0, errors = 0;
  int done_at, en_cnt, d_bad, done_cnt;
  ff_chain_test_ctrl #(.CHAIN_LEN(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
`ifdef FF_CHAIN_TEST_INJECT_EN
    .inject_err_i(inject_err_i),
`endif
    .start_i(start_i), .abort_i(abort_i), .seed_i(seed_i), .n_shifts_i(n_shifts_i),
    .chain_d_o(chain_d_o), .chain_en_o(chain_en_o), .chain_q_i(chain_q_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_cnt_o(err_cnt_o), .first_err_o(first_err_o));
  always #5 clk = ~clk;
  assign chain_q_i = ch[L-1];
  always @(posedge clk) begin
    logic [L-1:0] nx;
    nx = {ch[L-2:0], chain_d_o};
    if (stuck) nx[10] = 1'b0;
    if (chain_en_o) ch <= nx;
  end
  task automatic do_run(input logic [15:0] s, input int n, input int ab, input int sp, input int inj);
    logic [15:0] l;
    bit e;
    l = s == 16'h0 ? 16'h1 : s;
    ref_q.delete();
    d_q.delete();
    for (int i = 0; i < L + n; i++) begin
      ref_q.push_back(l[15]);
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    done_at = -1; en_cnt = 0; d_bad = 0; done_cnt = 0;
    @(negedge clk);
    start_i = 1; seed_i = s; n_shifts_i = CW'(n);
    @(negedge clk);
    for (int c = 1; c <= L + n + 5; c++) begin
      start_i = c == sp;
      abort_i = c == ab;
`ifdef FF_CHAIN_TEST_INJECT_EN
      inject_err_i = c == inj;
`endif
      if (chain_en_o) begin
        en_cnt++;
        d_q.push_back(chain_d_o);
        e = (c - 1 < ref_q.size()) ? ref_q[c-1] ^ (c == inj + 1) : 1'b0;
        if (chain_d_o !== e) d_bad++;
      end
      if (done_o === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      @(negedge clk);
    end
    start_i = 0; abort_i = 0;
`ifdef FF_CHAIN_TEST_INJECT_EN
    inject_err_i = 0;
`endif
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({chain_d_o, chain_en_o, busy_o, done_o, pass_o, err_cnt_o, first_err_o} !== {5'b0, 16'h0, 16'hFFFF}) begin
      errors++;
      $display("FAIL reset_state got %b%b%b%b%b %h %h want 00000 0000 ffff", chain_d_o, chain_en_o, busy_o, done_o, pass_o, err_cnt_o, first_err_o);
    end
    rst = 0;
  endtask
  task automatic test_ideal;
    do_run(16'hACE1, 200, -1, -1, -1);
    checks++; if (en_cnt != 264) begin errors++; $display("FAIL ideal_en_cycles got %0d want 264", en_cnt); end
    checks++; if (done_at != 265) begin errors++; $display("FAIL ideal_done_cycle got %0d want 265", done_at); end
    checks++; if (d_bad != 0) begin errors++; $display("FAIL ideal_chain_d got %0d bad bits want 0", d_bad); end
    checks++; if (err_cnt_o !== 16'h0) begin errors++; $display("FAIL ideal_err_cnt got %h want 0", err_cnt_o); end
    checks++; if (pass_o !== 1'b1) begin errors++; $display("FAIL ideal_pass got %b want 1", pass_o); end
    checks++; if (first_err_o !== 16'hFFFF) begin errors++; $display("FAIL ideal_first_err got %h want ffff", first_err_o); end
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 150);
      do_run(16'($urandom), n, -1, -1, -1);
      checks++; if (done_at != L + n + 1 || done_cnt != 1) begin errors++; $display("FAIL rand_done got %0d x%0d want %0d x1", done_at, done_cnt, L + n + 1); end
      checks++; if (d_bad != 0 || err_cnt_o !== 16'h0 || pass_o !== 1'b1) begin errors++; $display("FAIL rand_result got bad=%0d err=%h pass=%b want 0 0 1", d_bad, err_cnt_o, pass_o); end
    end
  endtask
  task automatic test_stuck;
    int exp_err, exp_first;
    stuck = 1;
    do_run(16'($urandom), 1000, -1, -1, -1);
    stuck = 0;
    exp_err = 0; exp_first = 16'hFFFF;
    for (int k = 0; k < 1000; k++) if (ref_q[k]) begin
      if (exp_err == 0) exp_first = k;
      exp_err++;
    end
    checks++; if (err_cnt_o !== CW'(exp_err)) begin errors++; $display("FAIL stuck_err_cnt got %0d want %0d", err_cnt_o, exp_err); end
    checks++; if (first_err_o !== CW'(exp_first)) begin errors++; $display("FAIL stuck_first_err got %0d want %0d", first_err_o, exp_first); end
    checks++; if (pass_o !== 1'b0 || done_cnt != 1) begin errors++; $display("FAIL stuck_pass got %b x%0d want 0 x1", pass_o, done_cnt); end
  endtask
  task automatic test_zero_n;
    do_run(16'($urandom), 0, -1, 10, -1);
    checks++; if (done_at != 65 || done_cnt != 1) begin errors++; $display("FAIL zero_done got %0d x%0d want 65 x1", done_at, done_cnt); end
    checks++; if (en_cnt != L || d_bad != 0) begin errors++; $display("FAIL zero_fill got en=%0d bad=%0d want 64 0", en_cnt, d_bad); end
    checks++; if (err_cnt_o !== 16'h0 || pass_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL zero_result got err=%h pass=%b busy=%b want 0 1 0", err_cnt_o, pass_o, busy_o); end
  endtask
  task automatic test_abort;
    do_run(16'($urandom), 200, L + 51, -1, -1);
    checks++; if (done_cnt != 0 || en_cnt != L + 51) begin errors++; $display("FAIL abort_stop got done=%0d en=%0d want 0 %0d", done_cnt, en_cnt, L + 51); end
    checks++; if (busy_o !== 1'b0 || pass_o !== 1'b0 || chain_en_o !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b pass=%b en=%b want 0 0 0", busy_o, pass_o, chain_en_o); end
    do_run(16'($urandom), 30, -1, -1, -1);
    checks++; if (done_at != L + 31 || pass_o !== 1'b1 || d_bad != 0) begin errors++; $display("FAIL abort_rerun got done=%0d pass=%b bad=%0d want %0d 1 0", done_at, pass_o, d_bad, L + 31); end
  endtask
  task automatic test_seed0_rst;
    bit a0[$];
    int diff;
    do_run(16'h0, 20, -1, -1, -1);
    a0 = d_q;
    checks++; if (d_bad != 0) begin errors++; $display("FAIL seed0_stream got %0d bad bits want 0", d_bad); end
    do_run(16'h1, 20, -1, -1, -1);
    diff = a0.size() == d_q.size() ? 0 : 1;
    for (int i = 0; i < a0.size() && i < d_q.size(); i++) if (a0[i] != d_q[i]) diff++;
    checks++; if (diff != 0) begin errors++; $display("FAIL seed0_vs_seed1 got %0d differences want 0", diff); end
    @(negedge clk);
    start_i = 1; seed_i = 16'($urandom); n_shifts_i = 50;
    @(negedge clk);
    start_i = 0;
    repeat (19) @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_prefill busy got %b want 1", busy_o); end
    rst = 1;
    #1;
    checks++;
    if ({chain_d_o, chain_en_o, busy_o, done_o, pass_o, err_cnt_o, first_err_o} !== {5'b0, 16'h0, 16'hFFFF}) begin
      errors++;
      $display("FAIL async_rst got %b%b%b%b%b %h %h want 00000 0000 ffff", chain_d_o, chain_en_o, busy_o, done_o, pass_o, err_cnt_o, first_err_o);
    end
    #2 rst = 0;
    repeat (3) @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_rst_idle busy got %b want 0", busy_o); end
  endtask
`ifdef FF_CHAIN_TEST_INJECT_EN
  task automatic test_inject;
    do_run(16'($urandom), 100, -1, -1, 5);
    checks++; if (err_cnt_o !== 16'd1 || first_err_o !== 16'd5) begin errors++; $display("FAIL inject_result got err=%0d first=%0d want 1 5", err_cnt_o, first_err_o); end
    checks++; if (pass_o !== 1'b0 || d_bad != 0) begin errors++; $display("FAIL inject_stream got pass=%b bad=%0d want 0 0", pass_o, d_bad); end
  endtask
`endif
  initial begin
    test_reset;
    test_ideal;
    test_stuck;
    test_zero_n;
    test_abort;
    test_seed0_rst;
`ifdef FF_CHAIN_TEST_INJECT_EN
    test_inject;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
